// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch stage: PC, imem read issue, decode hand-off
// Supports decode stalls (with capture of the returning word) and execute redirects with squash.
module fetch_stage #(
   parameter int              N        = 64,
   parameter logic [N-1:0]    RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall_D,
   input  logic          branch_taken_E,
   input  logic [N-1:0]  branch_target_E,
   output logic [N-1:0]  imem_addr,
   output logic          imem_en,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   instr_D,
   output logic [N-1:0]  pc_D,
   output logic          valid_D
);

   logic [N-1:0] fetch_pc_q, fetch_pc_d;
   logic [N-1:0] dec_pc_q, dec_pc_d;
   logic         dec_valid_q, dec_valid_d;
   logic         inflight_q, inflight_d;
   logic         held_q, held_d;
   logic [31:0]  instr_hold_q, instr_hold_d;
   logic [N-1:0] redirect_pc;

   assign redirect_pc = branch_target_E & ~(N'(3));

   assign imem_addr = fetch_pc_q;
   assign imem_en   = !reset && (!stall_D || branch_taken_E);
   assign pc_D      = dec_pc_q;
   assign valid_D   = dec_valid_q;
   // Memory output is only meaningful the cycle after a read; once stalled, use the captured copy.
   assign instr_D   = !dec_valid_q ? 32'h0 : (held_q ? instr_hold_q : imem_rdata);

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      dec_pc_d     = dec_pc_q;
      dec_valid_d  = dec_valid_q;
      inflight_d   = inflight_q;
      held_d       = held_q;
      instr_hold_d = instr_hold_q;
      if (branch_taken_E) begin
         fetch_pc_d  = redirect_pc;
         dec_pc_d    = redirect_pc;
         dec_valid_d = 1'b0;
         held_d      = 1'b0;
         inflight_d  = 1'b1;
      end else if (stall_D) begin
         inflight_d = 1'b0;
         // Capture only on the first stalled cycle, while the word from the last read is on the bus.
         if (!held_q && inflight_q) begin
            instr_hold_d = imem_rdata;
            held_d       = 1'b1;
         end
      end else begin
         fetch_pc_d  = fetch_pc_q + N'(4);
         dec_pc_d    = fetch_pc_q;
         dec_valid_d = 1'b1;
         held_d      = 1'b0;
         inflight_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         dec_pc_q     <= '0;
         dec_valid_q  <= 1'b0;
         inflight_q   <= 1'b0;
         held_q       <= 1'b0;
         instr_hold_q <= 32'h0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         dec_pc_q     <= dec_pc_d;
         dec_valid_q  <= dec_valid_d;
         inflight_q   <= inflight_d;
         held_q       <= held_d;
         instr_hold_q <= instr_hold_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
// Driver pushes per-cycle expectations from a decode-slot model; a negedge monitor pops and compares.
module tb_fetch_stage;

   localparam int          N         = 64;
   localparam logic [63:0] RESET_PC  = 64'h0;
   localparam logic [63:0] RESET_PC2 = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_D = 1'b0;
   logic        branch_taken_E = 1'b0;
   logic [63:0] branch_target_E = '0;
   logic [63:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr_D;
   logic [63:0] pc_D;
   logic        valid_D;

   logic        stall2 = 1'b0;
   logic        branch2 = 1'b0;
   logic [63:0] target2 = '0;
   logic [63:0] imem_addr2;
   logic        imem_en2;
   logic [31:0] imem_rdata2 = '0;
   logic [31:0] instr_D2;
   logic [63:0] pc_D2;
   logic        valid_D2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_stage #(.N(N), .RESET_PC(RESET_PC)) u_dut (
      .clk(clk), .reset(reset), .stall_D(stall_D), .branch_taken_E(branch_taken_E),
      .branch_target_E(branch_target_E), .imem_addr(imem_addr), .imem_en(imem_en),
      .imem_rdata(imem_rdata), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D)
   );

   fetch_stage #(.N(N), .RESET_PC(RESET_PC2)) u_dut2 (
      .clk(clk), .reset(reset), .stall_D(stall2), .branch_taken_E(branch2),
      .branch_target_E(target2), .imem_addr(imem_addr2), .imem_en(imem_en2),
      .imem_rdata(imem_rdata2), .instr_D(instr_D2), .pc_D(pc_D2), .valid_D(valid_D2)
   );

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'h0) return 32'hF840_1000;
      if (a == 64'h4) return 32'hF801_0000;
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
   endfunction

   // Synchronous instruction memory; garbage on cycles without a read.
   always @(posedge clk) begin
      imem_rdata  <= imem_en  ? mem_word(imem_addr)  : 32'($urandom());
      imem_rdata2 <= imem_en2 ? mem_word(imem_addr2) : 32'($urandom());
   end

   typedef struct {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        en;
      logic [63:0] addr;
   } exp_t;

   exp_t exp_q[$];

   logic        m_known = 1'b0;
   logic        m_valid = 1'b0;
   logic [63:0] m_pc    = '0;
   logic [63:0] m_fetch = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // Decode slot model: what sits in D is the instruction at m_pc, or nothing.
   task automatic cycle(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      stall_D = st;
      branch_taken_E = br;
      branch_target_E = tgt;
      if (m_known) begin
         e.valid = m_valid;
         e.pc    = m_pc;
         e.instr = m_valid ? mem_word(m_pc) : 32'h0;
         e.en    = !rst && (!st || br);
         e.addr  = m_fetch;
         exp_q.push_back(e);
      end
      if (rst) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_pc    = 64'h0;
         m_fetch = RESET_PC;
      end else if (br) begin
         m_valid = 1'b0;
         m_pc    = {tgt[63:2], 2'b00};
         m_fetch = {tgt[63:2], 2'b00};
      end else if (!st) begin
         m_valid = 1'b1;
         m_pc    = m_fetch;
         m_fetch = m_fetch + 64'd4;
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid_D", {63'h0, valid_D}, {63'h0, e.valid});
         chk("pc_D", pc_D, e.pc);
         chk("instr_D", {32'h0, instr_D}, {32'h0, e.instr});
         chk("imem_en", {63'h0, imem_en}, {63'h0, e.en});
         chk("imem_addr", imem_addr, e.addr);
      end
   end

   initial begin
      logic [63:0] tgt;
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("dut2_first_addr", imem_addr2, RESET_PC2);
      chk("dut2_first_en", {63'h0, imem_en2}, 64'h1);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("dut2_wrap_addr", imem_addr2, 64'h0);
      chk("dut2_pc_D", pc_D2, RESET_PC2);
      chk("dut2_valid_D", {63'h0, valid_D2}, 64'h1);
      chk("dut2_instr_D", {32'h0, instr_D2}, {32'h0, mem_word(RESET_PC2)});
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      // pc_D = 8 is presented here; hold decode for three cycles
      cycle(1'b0, 1'b1, 1'b0, 64'h0);
      cycle(1'b0, 1'b1, 1'b0, 64'h0);
      cycle(1'b0, 1'b1, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h40);
      cycle(1'b0, 1'b0, 1'b1, 64'h40);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b1, 1'b0, 64'h0);
      cycle(1'b0, 1'b1, 1'b1, 64'h80);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b1, 64'h43);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b1, 64'h100);
      cycle(1'b0, 1'b0, 1'b1, 64'h200);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b1, 1'b0, 64'h0);
      cycle(1'b1, 1'b1, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 3000; i++) begin
         tgt = ($urandom_range(0, 3) == 0) ? {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom())}
                                           : {32'h0, 32'($urandom())};
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0, tgt);
      end
      cycle(1'b0, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
